// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch/lap-timer block.
package stopwatch_pkg;

  // Status encodings, also driven directly on the status output.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_EXP   = 2'b11;

  localparam logic [5:0] SEC_MAX = 6'd59;

  // Prescaler register width; a one-tick-per-second setup still needs one bit.
  function automatic int presc_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

  // Out-of-range preset seconds saturate at 59.
  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Circular-buffer FIFO for captured lap times, show-ahead read port.
module lap_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              do_pop;
  logic              do_push;

  // Pointer advance with wrap at DEPTH, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO still lands when a pop frees the head slot.
  assign do_push  = push && (!full || do_pop);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rdata    = empty ? '0 : mem[rd_ptr];

  // Storage array write.
  // NOTE: the data array is deliberately not reset; empty masks stale contents and this keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and sticky overflow.
  // NOTE: every register here is assigned with <= so all state updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Up/down stopwatch with prescaler, countdown expiry and lap-capture FIFO.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int MIN_W         = 8,
  parameter int LAP_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           clear,
  input  logic                           mode,
  input  logic [MIN_W-1:0]               load_min,
  input  logic [5:0]                     load_sec,
  input  logic                           lap,
  input  logic                           lap_rd,
  output logic [MIN_W-1:0]               minutes,
  output logic [5:0]                     seconds,
  output logic [1:0]                     status,
  output logic                           expired,
  output logic                           lap_valid,
  output logic [MIN_W-1:0]               lap_min,
  output logic [5:0]                     lap_sec,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_overflow
);

  localparam int             PW         = presc_width(TICKS_PER_SEC);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam int             DATA_W     = MIN_W + 6;

  logic [1:0]       state_q,  state_d;
  logic [PW-1:0]    presc_q,  presc_d;
  logic [MIN_W-1:0] min_q,    min_d;
  logic [5:0]       sec_q,    sec_d;
  logic             mode_q,   mode_d;
  logic             exp_q,    exp_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              lap_push;
  logic              lap_pop;
  logic [DATA_W-1:0] fifo_rdata;

  // Next-state logic: clear > stop > start, then prescaler and time counting.
  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    sec_d   = sec_q;
    mode_d  = mode_q;
    exp_d   = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      min_d   = '0;
      sec_d   = '0;
      mode_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start) begin
            mode_d  = mode;
            presc_d = '0;
            if (mode) begin
              min_d = load_min;
              sec_d = clamp_sec(load_sec);
              if (load_min == '0 && clamp_sec(load_sec) == '0) begin
                state_d = ST_EXP;
                exp_d   = 1'b1;
              end else begin
                state_d = ST_RUN;
              end
            end else begin
              min_d   = '0;
              sec_d   = '0;
              state_d = ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (!mode_q) begin
              if (sec_q == SEC_MAX) begin
                sec_d = '0;
                min_d = min_q + MIN_W'(1);
              end else begin
                sec_d = sec_q + 6'd1;
              end
            end else begin
              if (sec_q == '0) begin
                sec_d = SEC_MAX;
                min_d = min_q - MIN_W'(1);
              end else begin
                sec_d = sec_q - 6'd1;
              end
              if (min_q == '0 && sec_q == 6'd1) begin
                state_d = ST_EXP;
                exp_d   = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        ST_PAUSE: begin
          if (!stop && start) state_d = ST_RUN;
        end

        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      mode_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      mode_q  <= mode_d;
      exp_q   <= exp_d;
    end
  end

  // Laps capture the time held before this edge; clear takes priority over both ends.
  assign lap_push = lap && !clear && (state_q == ST_RUN || state_q == ST_PAUSE);
  assign lap_pop  = lap_rd && !clear && !fifo_empty;

  lap_fifo #(
    .DEPTH  (LAP_DEPTH),
    .DATA_W (DATA_W)
  ) u_lap_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .push     (lap_push),
    .pop      (lap_pop),
    .wdata    ({min_q, sec_q}),
    .rdata    (fifo_rdata),
    .count    (lap_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (lap_overflow)
  );

  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign status    = state_q;
  assign expired   = exp_q;
  assign lap_valid = !fifo_empty;
  assign lap_min   = fifo_rdata[DATA_W-1:6];
  assign lap_sec   = fifo_rdata[5:0];

  // Full flag is informational here; overflow tracking lives in the FIFO.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Scoreboard bench for stopwatch_lap_timer (TICKS_PER_SEC=4, MIN_W=8, LAP_DEPTH=2).
module tb_stopwatch_lap_timer;

  localparam int TPS = 4;
  localparam int MW  = 8;
  localparam int LD  = 2;
  localparam int CW  = $clog2(LD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
  logic [MW-1:0] load_min = '0;
  logic [5:0]    load_sec = '0;
  logic          lap = 1'b0, lap_rd = 1'b0;
  logic [MW-1:0] minutes, lap_min;
  logic [5:0]    seconds, lap_sec;
  logic [1:0]    status;
  logic          expired, lap_valid, lap_overflow;
  logic [CW-1:0] lap_count;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(
    .TICKS_PER_SEC (TPS),
    .MIN_W         (MW),
    .LAP_DEPTH     (LD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .mode         (mode),
    .load_min     (load_min),
    .load_sec     (load_sec),
    .lap          (lap),
    .lap_rd       (lap_rd),
    .minutes      (minutes),
    .seconds      (seconds),
    .status       (status),
    .expired      (expired),
    .lap_valid    (lap_valid),
    .lap_min      (lap_min),
    .lap_sec      (lap_sec),
    .lap_count    (lap_count),
    .lap_overflow (lap_overflow)
  );

  typedef enum int {S_MIN, S_SEC, S_STATUS, S_EXP, S_LV, S_LMIN, S_LSEC, S_LCNT, S_OVF} sig_e;

  sig_e  sb_sig_q[$];
  int    sb_val_q[$];
  string sb_tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int observe(input sig_e s);
    case (s)
      S_MIN:    return int'(minutes);
      S_SEC:    return int'(seconds);
      S_STATUS: return int'(status);
      S_EXP:    return int'(expired);
      S_LV:     return int'(lap_valid);
      S_LMIN:   return int'(lap_min);
      S_LSEC:   return int'(lap_sec);
      S_LCNT:   return int'(lap_count);
      default:  return int'(lap_overflow);
    endcase
  endfunction

  task automatic sb_push(input string tag, input sig_e s, input int v);
    sb_tag_q.push_back(tag);
    sb_sig_q.push_back(s);
    sb_val_q.push_back(v);
  endtask

  // Compare every pending expectation against the current DUT outputs.
  task automatic sb_drain();
    while (sb_tag_q.size() > 0) begin
      string t;
      sig_e  s;
      int    v;
      t = sb_tag_q.pop_front();
      s = sb_sig_q.pop_front();
      v = sb_val_q.pop_front();
      check(t, observe(s), v);
    end
  endtask

  task automatic exp_time(input string tag, input int m, input int s, input int st);
    sb_push({tag, "_min"}, S_MIN, m);
    sb_push({tag, "_sec"}, S_SEC, s);
    sb_push({tag, "_status"}, S_STATUS, st);
  endtask

  task automatic exp_all_zero(input string tag);
    exp_time(tag, 0, 0, 0);
    sb_push({tag, "_expired"}, S_EXP, 0);
    sb_push({tag, "_lap_valid"}, S_LV, 0);
    sb_push({tag, "_lap_min"}, S_LMIN, 0);
    sb_push({tag, "_lap_sec"}, S_LSEC, 0);
    sb_push({tag, "_lap_count"}, S_LCNT, 0);
    sb_push({tag, "_overflow"}, S_OVF, 0);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycles(2);
    exp_all_zero("reset");
    sb_drain();
    rst = 1'b0;

    // 1. count up 5 s, then pause
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(20);
    exp_time("up5", 0, 5, 1);
    sb_drain();
    stop = 1'b1; cycles(1); stop = 1'b0;
    exp_time("stop", 0, 5, 2);
    sb_drain();
    cycles(40);
    exp_time("frozen", 0, 5, 2);
    sb_drain();

    // 2. seconds wrap and minutes wrap
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(54 * TPS);
    exp_time("to_059", 0, 59, 1);
    sb_drain();
    cycles(TPS);
    exp_time("to_100", 1, 0, 1);
    sb_drain();
    cycles((254 * 60 + 59) * TPS);
    exp_time("to_25559", 255, 59, 1);
    sb_drain();
    cycles(TPS);
    exp_time("min_wrap", 0, 0, 1);
    sb_drain();
    clear = 1'b1; cycles(1); clear = 1'b0;

    // 3. countdown from 0:02 to expiry
    mode = 1'b1; load_min = 8'd0; load_sec = 6'd2;
    start = 1'b1; cycles(1); start = 1'b0;
    exp_time("dn_load", 0, 2, 1);
    sb_drain();
    cycles(TPS);
    exp_time("dn_001", 0, 1, 1);
    sb_drain();
    cycles(TPS);
    exp_time("dn_000", 0, 0, 3);
    sb_push("exp_pulse", S_EXP, 1);
    sb_drain();
    cycles(1);
    sb_push("exp_one_cycle", S_EXP, 0);
    sb_push("exp_hold", S_STATUS, 3);
    sb_drain();
    start = 1'b1; cycles(1); start = 1'b0;
    sb_push("exp_start_ign", S_STATUS, 3);
    sb_drain();
    clear = 1'b1; cycles(1); clear = 1'b0;
    exp_time("exp_clear", 0, 0, 0);
    sb_drain();

    // 4. laps with overflow, pop, and push+pop when full
    mode = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(TPS);
    lap = 1'b1; cycles(1); lap = 1'b0;
    cycles(TPS - 1);
    lap = 1'b1; cycles(1); lap = 1'b0;
    cycles(TPS - 1);
    exp_time("lap3_time", 0, 3, 1);
    sb_drain();
    lap = 1'b1; cycles(1); lap = 1'b0;
    sb_push("lap_count_full", S_LCNT, 2);
    sb_push("lap_valid", S_LV, 1);
    sb_push("lap_head_min", S_LMIN, 0);
    sb_push("lap_head_sec", S_LSEC, 1);
    sb_push("lap_ovf", S_OVF, 1);
    sb_drain();
    lap_rd = 1'b1; cycles(1); lap_rd = 1'b0;
    sb_push("pop_head_sec", S_LSEC, 2);
    sb_push("pop_count", S_LCNT, 1);
    sb_drain();
    lap = 1'b1; cycles(1); lap = 1'b0;
    sb_push("refill_count", S_LCNT, 2);
    sb_drain();
    lap = 1'b1; lap_rd = 1'b1; cycles(1); lap = 1'b0; lap_rd = 1'b0;
    sb_push("pushpop_count", S_LCNT, 2);
    sb_push("pushpop_head", S_LSEC, 3);
    sb_push("pushpop_ovf", S_OVF, 1);
    sb_drain();

    // 5. stop beats start; preset seconds clamp
    start = 1'b1; stop = 1'b1; cycles(1); start = 1'b0; stop = 1'b0;
    sb_push("stop_wins", S_STATUS, 2);
    sb_drain();
    clear = 1'b1; cycles(1); clear = 1'b0;
    sb_push("clr_lap_count", S_LCNT, 0);
    sb_push("clr_lap_valid", S_LV, 0);
    sb_push("clr_ovf", S_OVF, 0);
    sb_drain();
    mode = 1'b1; load_min = 8'd0; load_sec = 6'd63;
    start = 1'b1; cycles(1); start = 1'b0;
    exp_time("clamp", 0, 59, 1);
    sb_drain();

    // 6. reset mid-countdown with one lap stored
    cycles(6);
    lap = 1'b1; cycles(1); lap = 1'b0;
    sb_push("pre_rst_count", S_LCNT, 1);
    exp_time("pre_rst", 0, 58, 1);
    sb_drain();
    rst = 1'b1; cycles(1); rst = 1'b0;
    exp_all_zero("rst_mid");
    sb_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
